// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode width filter: the layout of the 32-bit
// word handed to the SPI sender and a helper that assembles it.
package barcode_pkg;

    localparam int COUNT_MSB = 31;
    localparam int COUNT_LSB = 24;
    localparam int LEVEL_BIT = 23;
    localparam int SAT_BIT   = 22;
    localparam int WIDTH_MSB = 15;
    localparam int WIDTH_LSB = 0;

    typedef struct packed {
        logic [7:0]  count;
        logic        level;
        logic        sat;
        logic [5:0]  rsvd;
        logic [15:0] width;
    } word_t;

    // Reserved bits [21:16] always read as zero.
    function automatic word_t make_word(input logic [7:0]  count,
                                        input logic        level,
                                        input logic        sat,
                                        input logic [15:0] width);
        logic [31:0] w;
        w = '0;
        w[COUNT_MSB:COUNT_LSB] = count;
        w[LEVEL_BIT]           = level;
        w[SAT_BIT]             = sat;
        w[WIDTH_MSB:WIDTH_LSB] = width;
        return word_t'(w);
    endfunction

endpackage

// File: rtl/barcode_width_filter_if.sv
// Link between the width filter and the SPI sender: chip enable from the MCU
// in, the frozen measurement word and its update strobe out.
interface barcode_width_filter_if;
    import barcode_pkg::*;

    logic  ce;
    word_t filtered;
    logic  new_word;

    modport master (input ce, output filtered, output new_word);
    modport slave  (output ce, input filtered, input new_word);

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; RST_VAL selects the
// level both flops take during reset.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: flop outputs are written with <= so every register samples the
    // pre-edge values; blocking '=' here would collapse the two stages into one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/barcode_width_filter.sv
// Debounces the photodiode bit, measures bar/space widths, averages the last
// 2**WIN_LOG2 widths and hands a word to the SPI sender, frozen while ce is low.
module barcode_width_filter
    import barcode_pkg::*;
#(
    parameter int DEBOUNCE = 8,
    parameter int CNT_W    = 16,
    parameter int WIN_LOG2 = 2
) (
    input logic                    clk,
    input logic                    reset_n,
    input logic                    bar_in,
    barcode_width_filter_if.master link
);

    localparam int DEPTH = 1 << WIN_LOG2;
    localparam int SUM_W = CNT_W + WIN_LOG2;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  RUN_MAX   = '1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
    localparam logic [WIN_LOG2:0] FILL_FULL = (WIN_LOG2 + 1)'(DEPTH);

    logic bar_s;
    logic ce_s;

    sync2 #(.RST_VAL(1'b0)) u_bar_sync (.clk(clk), .reset_n(reset_n), .d(bar_in),  .q(bar_s));
    sync2 #(.RST_VAL(1'b1)) u_ce_sync  (.clk(clk), .reset_n(reset_n), .d(link.ce), .q(ce_s));

    logic             lvl;
    logic [DB_W-1:0]  db_cnt;
    logic             differs;
    logic             bar_edge;
    logic [CNT_W-1:0] run_cnt;
    logic             run_sat;
    logic             first_seen;
    logic             push;
    logic             push_d;
    logic [CNT_W-1:0] win [DEPTH];
    logic [SUM_W-1:0] sum;
    logic [WIN_LOG2:0] fill;
    logic [7:0]       bar_count;
    logic             last_level;
    logic             last_sat;
    logic [15:0]      avg;
    logic             stage_load;
    logic             transfer;
    logic             pending;
    word_t            stage_word;

    assign differs    = (bar_s != lvl);
    assign bar_edge   = differs && (db_cnt == DB_LAST);
    assign run_sat    = (run_cnt == RUN_MAX);
    // The run that is open when reset releases has no known start.
    assign push       = bar_edge && first_seen;
    assign avg        = 16'(sum >> WIN_LOG2);
    assign stage_load = push_d && (fill == FILL_FULL);
    assign transfer   = pending && ce_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl        <= 1'b0;
            db_cnt     <= '0;
            run_cnt    <= '0;
            first_seen <= 1'b0;
        end else begin
            if (bar_edge) begin
                lvl    <= ~lvl;
                db_cnt <= '0;
            end else if (differs) begin
                db_cnt <= db_cnt + 1'b1;
            end else begin
                db_cnt <= '0;
            end

            if (bar_edge)      run_cnt <= CNT_W'(1);
            else if (!run_sat) run_cnt <= run_cnt + 1'b1;

            first_seen <= first_seen | bar_edge;
        end
    end

    // NOTE: the window entries are reset along with the sum because the
    // running sum subtracts the oldest entry even while the window is filling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) win[i] <= '0;
            sum        <= '0;
            fill       <= '0;
            bar_count  <= '0;
            last_level <= 1'b0;
            last_sat   <= 1'b0;
            push_d     <= 1'b0;
        end else begin
            push_d <= push;
            if (push) begin
                win[0] <= run_cnt;
                for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
                sum        <= sum + SUM_W'(run_cnt) - SUM_W'(win[DEPTH-1]);
                bar_count  <= bar_count + 1'b1;
                last_level <= lvl;
                last_sat   <= run_sat;
                if (fill != FILL_FULL) fill <= fill + 1'b1;
            end
        end
    end

    // A load coinciding with a transfer keeps pending set for the newer word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_word    <= '0;
            pending       <= 1'b0;
            link.filtered <= '0;
            link.new_word <= 1'b0;
        end else begin
            link.new_word <= transfer;
            if (transfer) link.filtered <= stage_word;

            if (stage_load) begin
                stage_word <= make_word(bar_count, last_level, last_sat, avg);
                pending    <= 1'b1;
            end else if (transfer) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_barcode_width_filter.sv
// Self-checking bench for barcode_width_filter: directed scenarios plus random
// run lengths, compared against a run-length/average model of the filter.
module tb_barcode_width_filter;
    import barcode_pkg::*;

    localparam int LAT     = 2 + 8 + 2;   // sync + debounce + stage/output
    localparam int CE_LAT  = 3;
    localparam int RUN_MAX = 65535;

    typedef struct {
        word_t word;
        int    due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    logic bar_in;

    barcode_width_filter_if link();

    barcode_width_filter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bar_in  (bar_in),
        .link    (link)
    );

    always #5 clk = ~clk;

    exp_t  expq[$];
    int    widths[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_tog = 0;
    int    n_push = 0;
    int    nw_count = 0;
    bit    started = 1'b0;
    bit    frozen = 1'b0;
    bit    held_valid = 1'b0;
    word_t held;
    word_t last_word;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        expq.delete();
        widths.delete();
        n_push     = 0;
        started    = 1'b0;
        held_valid = 1'b0;
        last_word  = '0;
    endtask

    // Flip the input and, from the model's view, close the run that just ended.
    task automatic toggle_bar();
        int    len;
        int    w;
        int    s;
        word_t e;
        bar_in = ~bar_in;
        if (started) begin
            len = cyc - last_tog;
            w   = (len > RUN_MAX) ? RUN_MAX : len;
            widths.push_back(w);
            if (widths.size() > 4) void'(widths.pop_front());
            n_push++;
            if (widths.size() == 4) begin
                s = 0;
                foreach (widths[i]) s += widths[i];
                e       = '0;
                e.count = 8'(n_push);
                e.level = ~bar_in;
                e.sat   = (len >= RUN_MAX);
                e.width = 16'(s / 4);
                if (frozen) begin
                    held       = e;
                    held_valid = 1'b1;
                end else begin
                    expq.push_back('{word: e, due: cyc + LAT});
                end
            end
        end
        started  = 1'b1;
        last_tog = cyc;
    endtask

    always @(negedge clk) begin : monitor
        exp_t got_e;
        if (reset_n === 1'b1) begin
            if (link.new_word === 1'b1) begin
                nw_count++;
                if (expq.size() == 0) begin
                    check("spurious_new_word", 32'(link.new_word), 32'd0);
                end else begin
                    got_e = expq.pop_front();
                    check("word", link.filtered, got_e.word);
                    check("latency", cyc, got_e.due);
                    last_word = got_e.word;
                end
            end else begin
                check("filtered_hold", link.filtered, last_word);
                if (expq.size() > 0 && cyc > expq[0].due) begin
                    check("missing_new_word", 32'(link.new_word), 32'd1);
                    void'(expq.pop_front());
                end
            end
        end
    end

    initial begin
        int    t3_runs[4];
        int    nw_before;
        logic  lvl_last;
        word_t frozen_word;

        t3_runs = '{40, 80, 120, 160};
        reset_n = 1'b0;
        bar_in  = 1'b0;
        link.ce = 1'b1;
        model_reset();
        wait_clks(3);
        check("rst_filtered", link.filtered, 32'd0);
        check("rst_new_word", 32'(link.new_word), 32'd0);
        reset_n = 1'b1;
        wait_clks(5);

        // Glitches shorter than the debounce window must be ignored.
        repeat (6) begin
            bar_in = 1'b1;
            wait_clks(4);
            bar_in = 1'b0;
            wait_clks(6);
        end
        wait_clks(20);
        check("t1_no_word", nw_count, 0);
        check("t1_filtered", link.filtered, 32'd0);

        // Square wave of 100-cycle runs: first run discarded, word on 5th edge.
        toggle_bar();
        repeat (7) begin
            wait_clks(100);
            toggle_bar();
        end
        wait_clks(LAT + 4);
        check("t2_words", nw_count, 4);
        check("t2_width", 32'(link.filtered[15:0]), 32'd100);

        // Mixed runs averaging to 100.
        wait_clks(30);
        toggle_bar();
        foreach (t3_runs[i]) begin
            wait_clks(t3_runs[i]);
            toggle_bar();
        end
        lvl_last = ~bar_in;
        wait_clks(LAT + 4);
        check("t3_avg", 32'(link.filtered[15:0]), 32'd100);
        check("t3_level", 32'(link.filtered[23]), 32'(lvl_last));

        // A run longer than the counter range saturates.
        wait_clks(66000);
        toggle_bar();
        wait_clks(LAT + 4);
        check("t4_sat", 32'(link.filtered[22]), 32'd1);
        check("t4_width", 32'(link.filtered[15:0]), 32'((80 + 120 + 160 + 65535) / 4));

        // Hold ce low across three runs: output frozen, then only the latest word.
        wait_clks(20);
        link.ce     = 1'b0;
        frozen      = 1'b1;
        nw_before   = nw_count;
        frozen_word = last_word;
        wait_clks(5);
        repeat (3) begin
            wait_clks($urandom_range(20, 60));
            toggle_bar();
        end
        wait_clks(30);
        check("t5_frozen", link.filtered, frozen_word);
        check("t5_no_word", nw_count, nw_before);
        frozen  = 1'b0;
        link.ce = 1'b1;
        if (held_valid) expq.push_back('{word: held, due: cyc + CE_LAT});
        held_valid = 1'b0;
        wait_clks(10);
        check("t5_delivered", nw_count, nw_before + 1);

        // Reset while a word is staged but not yet delivered.
        wait_clks(20);
        toggle_bar();
        wait_clks(LAT - 1);
        reset_n = 1'b0;
        bar_in  = 1'b0;
        model_reset();
        wait_clks(1);
        check("t6_rst_filtered", link.filtered, 32'd0);
        check("t6_rst_new_word", 32'(link.new_word), 32'd0);
        wait_clks(3);
        reset_n   = 1'b1;
        nw_before = nw_count;
        wait_clks(20);
        repeat (4) begin
            wait_clks($urandom_range(15, 50));
            toggle_bar();
        end
        wait_clks(LAT + 4);
        check("t6_quiet", nw_count, nw_before);
        wait_clks(20);
        toggle_bar();
        wait_clks(LAT + 4);
        check("t6_first_word", nw_count, nw_before + 1);

        // Random run lengths.
        repeat (40) begin
            wait_clks($urandom_range(10, 300));
            toggle_bar();
        end
        wait_clks(LAT + 10);
        check("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
